regfile_reader: RTL and testbench
=================================

REGFILE_READER -- requirements
Module: regfile_reader

Interface
REQ-001 SHALL have parameter NREG, default 32, number of 32-bit registers (R0..NREG-1).
REQ-002 SHALL have parameter AW, default 5, address width; NREG == 2**AW.
REQ-003 Clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Clr  input  1  reset; synchronous, active-high.
REQ-005 We  input  1  write enable.
REQ-006 Wn  input  AW  write address.
REQ-007 D  input  32  write data.
REQ-008 RreqA / RreqB  input  1  read request, port A / B.
REQ-009 RaddrA / RaddrB  input  AW  read address, port A / B.
REQ-010 RreadyA / RreadyB  input  1  consumer ready, port A / B.
REQ-011 RvalidA / RvalidB  output  1  read data valid, port A / B.
REQ-012 QA / QB  output  32  registered read data, port A / B.

Function
REQ-013 Write: We=1 and Wn!=0 at a rising edge SHALL load D into R[Wn]; We=1 with Wn=0 SHALL be ignored.
REQ-014 R0 SHALL read as 0x00000000 at all times.
REQ-015 Each port SHALL be a two-state FSM: IDLE (Rvalid=0), HOLD (Rvalid=1).
REQ-016 Request accepted at an edge when Rreq=1 and (state IDLE, or state HOLD with Rready=1).
REQ-017 Accepted request: Q SHALL take R[Raddr] and Rvalid SHALL be 1 at the next edge (1-cycle latency); state HOLD.
REQ-018 HOLD with Rready=1 and Rreq=0: SHALL return to IDLE, Rvalid=0; Q holds last value.
REQ-019 HOLD with Rready=0: Q and Rvalid SHALL stay stable, new Rreq not accepted, even if R[Raddr] is written meanwhile (snapshot semantics).
REQ-020 Back-to-back: HOLD, Rready=1, Rreq=1 SHALL deliver the next word on the following edge with no bubble (one read per cycle per port).
REQ-021 Ports A and B SHALL be independent; both may read the same address in the same cycle.
REQ-022 Address >= NREG cannot occur (NREG==2**AW); no range check needed.

Reset
REQ-023 Clr=1 at an edge SHALL clear all R[i] to 0, both FSMs to IDLE, RvalidA/B=0, QA/QB=0x00000000.
REQ-024 Clr SHALL take priority over We and Rreq in the same cycle; an in-flight HOLD word SHALL be dropped.
REQ-025 First request SHALL be accepted on the first edge with Clr=0.

Configuration
REQ-026 Macro REGFILE_BYPASS_EN defined: accepted read with We=1, Wn==Raddr, Wn!=0 in the same cycle SHALL return D (write-through).
REQ-027 Macro undefined: that read SHALL return the old R[Raddr]; new value visible from the next accepted read.

Structure
REQ-028 Package regfile_pkg SHALL hold DATA_W=32, default NREG/AW, and the port FSM state enum (IDLE, HOLD).
REQ-029 One sub-module regfile_rd_port (FSM, Q/Rvalid register, bypass mux) SHALL be instantiated twice; storage array and write logic in top.

Verification
REQ-030 Clr=1 one edge after writing R3=0xFFFFFFFF -> QA=QB=0, Rvalid=0; then read R3 -> QA=0x00000000.
REQ-031 Write R5=0x0F0F0F0F, next cycle RreqA addr 5, RreadyA=1 -> one edge later RvalidA=1, QA=0x0F0F0F0F.
REQ-032 Same-cycle We R7=0xF0F0F0F0 and RreqB addr 7, R7 previously 0x33333333 -> QB=0xF0F0F0F0 with REGFILE_BYPASS_EN, 0x33333333 without.
REQ-033 Write R0=0xCCCCCCCC, read R0 on both ports -> QA=QB=0x00000000.
REQ-034 RreadyA=0 in HOLD holding R2=0x11111111 for 3 cycles while R2 written 0x22222222 -> QA stays 0x11111111, RvalidA=1; on release with Rreq addr 2 -> next QA=0x22222222.
REQ-035 Stream RreqA addr 1,2,3,4 with RreadyA=1 every cycle -> four consecutive valid words, no gap, in order.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file reader.
// Optional feature macro: REGFILE_BYPASS_EN (write-through on same-cycle read).
package regfile_pkg;

    localparam int DATA_W   = 32;
    localparam int DEF_NREG = 32;
    localparam int DEF_AW   = 5;

    // Per-port read FSM: IDLE has no word on offer, HOLD presents a word until taken.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } port_state_t;

endpackage

// File: rtl/regfile_rd_port.sv
// One read port: two-state FSM, registered read data/valid, optional write bypass.
// Optional feature macro: REGFILE_BYPASS_EN (a read that collides with a same-cycle
// write to the same non-zero register returns the incoming write data).
//
// Handshake: o_rvalid=1 means o_q holds a word on offer. A request (i_rreq=1) is
// accepted at an edge when the port is IDLE, or HOLD with i_rready=1 (the offered
// word is consumed in that same edge). While HOLD and i_rready=0, o_q/o_rvalid are
// frozen and new requests wait; the word is a snapshot taken at acceptance.
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int AW = DEF_AW
) (
    input  logic              i_clk,
    input  logic              i_clr,
    input  logic              i_rreq,
    input  logic [AW-1:0]     i_raddr,
    input  logic              i_rready,
    input  logic [DATA_W-1:0] i_rdata,
    input  logic              i_we,
    input  logic [AW-1:0]     i_wn,
    input  logic [DATA_W-1:0] i_d,
    output logic              o_rvalid,
    output logic [DATA_W-1:0] o_q,
    output port_state_t       o_state
);

    port_state_t       r_state;
    logic [DATA_W-1:0] r_q;
    logic              w_accept;
    logic [DATA_W-1:0] w_data;

    assign w_accept = i_rreq && ((r_state == ST_IDLE) || i_rready);

`ifdef REGFILE_BYPASS_EN
    // Write-through: a same-cycle write to the requested register wins over storage.
    always_comb begin
        w_data = i_rdata;
        if (i_we && (i_wn == i_raddr) && (i_wn != '0)) begin
            w_data = i_d;
        end
    end
`else
    // Without bypass the read sees storage as it was before this edge's write.
    logic w_unused_bypass;
    assign w_unused_bypass = ^{i_we, i_wn, i_d};
    assign w_data = i_rdata;
`endif

    // FSM and output register: capture on accept, drop to IDLE once the word is taken.
    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_state <= ST_IDLE;
            r_q     <= '0;
        end else if (w_accept) begin
            r_state <= ST_HOLD;
            r_q     <= w_data;
        end else if ((r_state == ST_HOLD) && i_rready) begin
            r_state <= ST_IDLE;
        end
    end

    assign o_rvalid = (r_state == ST_HOLD);
    assign o_q      = r_q;
    assign o_state  = r_state;

endmodule

// File: rtl/regfile_reader.sv
// Register file (NREG x 32, R0 hard-wired to zero) with two independent
// handshaked read ports. Storage and write logic live here; each read port is
// a regfile_rd_port instance.
// Optional feature macro: REGFILE_BYPASS_EN (same-cycle write-through on reads).
module regfile_reader
    import regfile_pkg::*;
#(
    parameter int NREG = DEF_NREG,
    parameter int AW   = DEF_AW
) (
    input  logic              Clk,
    input  logic              Clr,
    input  logic              We,
    input  logic [AW-1:0]     Wn,
    input  logic [DATA_W-1:0] D,
    input  logic              RreqA,
    input  logic [AW-1:0]     RaddrA,
    input  logic              RreadyA,
    input  logic              RreqB,
    input  logic [AW-1:0]     RaddrB,
    input  logic              RreadyB,
    output logic              RvalidA,
    output logic [DATA_W-1:0] QA,
    output logic              RvalidB,
    output logic [DATA_W-1:0] QB,
    output logic              o_dbg_state_a,
    output logic              o_dbg_state_b
);

    logic [DATA_W-1:0] r_regs [NREG];
    logic [DATA_W-1:0] w_rdata_a;
    logic [DATA_W-1:0] w_rdata_b;
    port_state_t       w_state_a;
    port_state_t       w_state_b;

    // Storage: clear on Clr, otherwise write any register except R0.
    always_ff @(posedge Clk) begin
        if (Clr) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (We && (Wn != '0)) begin
            r_regs[Wn] <= D;
        end
    end

    // R0 reads as zero regardless of storage contents.
    assign w_rdata_a = (RaddrA == '0) ? '0 : r_regs[RaddrA];
    assign w_rdata_b = (RaddrB == '0) ? '0 : r_regs[RaddrB];

    regfile_rd_port #(.AW(AW)) u_port_a (
        .i_clk    (Clk),
        .i_clr    (Clr),
        .i_rreq   (RreqA),
        .i_raddr  (RaddrA),
        .i_rready (RreadyA),
        .i_rdata  (w_rdata_a),
        .i_we     (We),
        .i_wn     (Wn),
        .i_d      (D),
        .o_rvalid (RvalidA),
        .o_q      (QA),
        .o_state  (w_state_a)
    );

    regfile_rd_port #(.AW(AW)) u_port_b (
        .i_clk    (Clk),
        .i_clr    (Clr),
        .i_rreq   (RreqB),
        .i_raddr  (RaddrB),
        .i_rready (RreadyB),
        .i_rdata  (w_rdata_b),
        .i_we     (We),
        .i_wn     (Wn),
        .i_d      (D),
        .o_rvalid (RvalidB),
        .o_q      (QB),
        .o_state  (w_state_b)
    );

    assign o_dbg_state_a = w_state_a;
    assign o_dbg_state_b = w_state_b;

endmodule

// File: tb/tb_regfile_reader.sv
// Testbench for regfile_reader: directed scenarios plus a randomized run,
// all checked against a behavioural register-file model.
// Honours REGFILE_BYPASS_EN the same way the design does.
module tb_regfile_reader;

    localparam int NREG = 32;
    localparam int AW   = 5;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic          Clk;
    logic          Clr;
    logic          We;
    logic [AW-1:0] Wn;
    logic [31:0]   D;
    logic          RreqA, RreqB;
    logic [AW-1:0] RaddrA, RaddrB;
    logic          RreadyA, RreadyB;
    logic          RvalidA, RvalidB;
    logic [31:0]   QA, QB;
    logic          o_dbg_state_a, o_dbg_state_b;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model: register contents plus, per port, "is a word on offer" and the word.
    logic [31:0] m_regs [NREG];
    bit          m_hold_a, m_hold_b;
    logic [31:0] m_q_a, m_q_b;

    regfile_reader #(.NREG(NREG), .AW(AW)) dut (
        .Clk           (Clk),
        .Clr           (Clr),
        .We            (We),
        .Wn            (Wn),
        .D             (D),
        .RreqA         (RreqA),
        .RaddrA        (RaddrA),
        .RreadyA       (RreadyA),
        .RreqB         (RreqB),
        .RaddrB        (RaddrB),
        .RreadyB       (RreadyB),
        .RvalidA       (RvalidA),
        .QA            (QA),
        .RvalidB       (RvalidB),
        .QB            (QB),
        .o_dbg_state_a (o_dbg_state_a),
        .o_dbg_state_b (o_dbg_state_b)
    );

    // Clock
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [31:0] model_read(input logic [AW-1:0] a);
        if (a == 0) return 32'h0;
        if (BYPASS && We && (Wn == a)) return D;
        return m_regs[a];
    endfunction

    // Advance the model by one edge from the current inputs, then let the DUT take the edge.
    task automatic tick();
        if (Clr) begin
            for (int i = 0; i < NREG; i++) m_regs[i] = 32'h0;
            m_hold_a = 0; m_hold_b = 0; m_q_a = 32'h0; m_q_b = 32'h0;
        end else begin
            if (RreqA && (!m_hold_a || RreadyA)) begin
                m_q_a = model_read(RaddrA); m_hold_a = 1;
            end else if (m_hold_a && RreadyA) begin
                m_hold_a = 0;
            end
            if (RreqB && (!m_hold_b || RreadyB)) begin
                m_q_b = model_read(RaddrB); m_hold_b = 1;
            end else if (m_hold_b && RreadyB) begin
                m_hold_b = 0;
            end
            if (We && (Wn != 0)) m_regs[Wn] = D;
        end
        @(posedge Clk);
        #1;
    endtask

    // Driver: quiet bus, consumers ready.
    task automatic drive_idle();
        Clr = 0; We = 0; Wn = '0; D = 32'h0;
        RreqA = 0; RaddrA = '0; RreadyA = 1;
        RreqB = 0; RaddrB = '0; RreadyB = 1;
    endtask

    task automatic drive_write(input logic [AW-1:0] a, input logic [31:0] d);
        We = 1; Wn = a; D = d;
    endtask

    task automatic test_reset();
        drive_idle();
        Clr = 1;
        tick(); tick();
        Clr = 0;
        drive_write(5'd3, 32'hFFFFFFFF);
        tick();
        We = 0; Clr = 1;
        tick();
        n_checks++;
        if (QA !== 32'h0 || QB !== 32'h0) begin
            n_errors++; $display("FAIL reset_q QA=%h QB=%h expected 0", QA, QB);
        end
        n_checks++;
        if (RvalidA !== 1'b0 || RvalidB !== 1'b0 || o_dbg_state_a !== 1'b0 || o_dbg_state_b !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_valid RvalidA=%b RvalidB=%b stA=%b stB=%b expected 0", RvalidA, RvalidB, o_dbg_state_a, o_dbg_state_b);
        end
        // First edge with Clr low must accept the request.
        Clr = 0; RreqA = 1; RaddrA = 5'd3;
        tick();
        n_checks++;
        if (RvalidA !== 1'b1 || QA !== 32'h0) begin
            n_errors++; $display("FAIL reset_r3_cleared RvalidA=%b QA=%h expected 1/00000000", RvalidA, QA);
        end
        drive_idle(); tick();
    endtask

    task automatic test_write_read();
        drive_idle();
        drive_write(5'd5, 32'h0F0F0F0F);
        tick();
        We = 0; RreqA = 1; RaddrA = 5'd5;
        tick();
        n_checks++;
        if (RvalidA !== 1'b1 || QA !== 32'h0F0F0F0F) begin
            n_errors++; $display("FAIL write_read RvalidA=%b QA=%h expected 1/0f0f0f0f", RvalidA, QA);
        end
        RreqA = 0;
        tick();
        n_checks++;
        if (RvalidA !== 1'b0 || QA !== 32'h0F0F0F0F) begin
            n_errors++; $display("FAIL release_idle RvalidA=%b QA=%h expected 0/0f0f0f0f", RvalidA, QA);
        end
    endtask

    task automatic test_bypass();
        logic [31:0] exp_q;
        exp_q = BYPASS ? 32'hF0F0F0F0 : 32'h33333333;
        drive_idle();
        drive_write(5'd7, 32'h33333333);
        tick();
        drive_write(5'd7, 32'hF0F0F0F0);
        RreqB = 1; RaddrB = 5'd7;
        tick();
        n_checks++;
        if (RvalidB !== 1'b1 || QB !== exp_q) begin
            n_errors++; $display("FAIL same_cycle_rw RvalidB=%b QB=%h expected 1/%h", RvalidB, QB, exp_q);
        end
        We = 0;
        tick();
        n_checks++;
        if (QB !== 32'hF0F0F0F0) begin
            n_errors++; $display("FAIL rw_next_read QB=%h expected f0f0f0f0", QB);
        end
        drive_idle(); tick();
    endtask

    task automatic test_r0();
        drive_idle();
        drive_write(5'd0, 32'hCCCCCCCC);
        tick();
        We = 0; RreqA = 1; RaddrA = 5'd0; RreqB = 1; RaddrB = 5'd0;
        tick();
        n_checks++;
        if (QA !== 32'h0 || QB !== 32'h0 || RvalidA !== 1'b1 || RvalidB !== 1'b1) begin
            n_errors++; $display("FAIL r0_zero QA=%h QB=%h vA=%b vB=%b expected 0/0/1/1", QA, QB, RvalidA, RvalidB);
        end
        drive_idle(); tick();
    endtask

    task automatic test_hold_snapshot();
        drive_idle();
        drive_write(5'd2, 32'h11111111);
        tick();
        We = 0; RreqA = 1; RaddrA = 5'd2; RreadyA = 0;
        tick();
        drive_write(5'd2, 32'h22222222);
        for (int i = 0; i < 3; i++) begin
            tick();
            We = 0;
            n_checks++;
            if (QA !== 32'h11111111 || RvalidA !== 1'b1 || o_dbg_state_a !== 1'b1) begin
                n_errors++; $display("FAIL hold_stable cyc=%0d QA=%h RvalidA=%b expected 11111111/1", i, QA, RvalidA);
            end
        end
        RreadyA = 1;
        tick();
        n_checks++;
        if (QA !== 32'h22222222 || RvalidA !== 1'b1) begin
            n_errors++; $display("FAIL hold_release QA=%h RvalidA=%b expected 22222222/1", QA, RvalidA);
        end
        drive_idle(); tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals [4];
        drive_idle();
        for (int i = 0; i < 4; i++) begin
            vals[i] = $urandom;
            drive_write(AW'(i + 1), vals[i]);
            tick();
        end
        We = 0; RreqA = 1;
        for (int i = 0; i < 4; i++) begin
            RaddrA = AW'(i + 1);
            tick();
            n_checks++;
            if (RvalidA !== 1'b1 || QA !== vals[i]) begin
                n_errors++; $display("FAIL stream word=%0d RvalidA=%b QA=%h expected 1/%h", i, RvalidA, QA, vals[i]);
            end
        end
        drive_idle(); tick();
    endtask

    task automatic test_clr_priority();
        drive_idle();
        drive_write(5'd9, 32'hAAAAAAAA);
        tick();
        We = 0; RreqA = 1; RaddrA = 5'd9; RreadyA = 0;
        tick();
        Clr = 1; drive_write(5'd9, 32'h55555555); RreqB = 1; RaddrB = 5'd9;
        tick();
        n_checks++;
        if (RvalidA !== 1'b0 || QA !== 32'h0 || RvalidB !== 1'b0 || QB !== 32'h0) begin
            n_errors++; $display("FAIL clr_priority vA=%b QA=%h vB=%b QB=%h expected all 0", RvalidA, QA, RvalidB, QB);
        end
        drive_idle(); RreqA = 1; RaddrA = 5'd9;
        tick();
        n_checks++;
        if (RvalidA !== 1'b1 || QA !== 32'h0) begin
            n_errors++; $display("FAIL clr_drops_write RvalidA=%b QA=%h expected 1/00000000", RvalidA, QA);
        end
        drive_idle(); tick();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            Clr     = ($urandom_range(0, 99) < 2);
            We      = ($urandom_range(0, 1) == 1);
            Wn      = AW'($urandom_range(0, 7));
            D       = $urandom;
            RreqA   = ($urandom_range(0, 9) < 6);
            RaddrA  = AW'($urandom_range(0, 1) == 1 ? $urandom_range(0, 7) : $urandom_range(0, NREG - 1));
            RreadyA = ($urandom_range(0, 9) < 7);
            RreqB   = ($urandom_range(0, 9) < 6);
            RaddrB  = ($urandom_range(0, 3) == 0) ? RaddrA : AW'($urandom_range(0, 7));
            RreadyB = ($urandom_range(0, 9) < 7);
            tick();
            n_checks++;
            if (RvalidA !== m_hold_a || QA !== m_q_a || o_dbg_state_a !== m_hold_a) begin
                n_errors++; $display("FAIL rand_port_a n=%0d vA=%b QA=%h expected %b/%h", n, RvalidA, QA, m_hold_a, m_q_a);
            end
            n_checks++;
            if (RvalidB !== m_hold_b || QB !== m_q_b || o_dbg_state_b !== m_hold_b) begin
                n_errors++; $display("FAIL rand_port_b n=%0d vB=%b QB=%h expected %b/%h", n, RvalidB, QB, m_hold_b, m_q_b);
            end
        end
        drive_idle(); tick();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_bypass();
        test_r0();
        test_hold_snapshot();
        test_back_to_back();
        test_clr_priority();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
